// File: rtl/reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : reg_bank                                                   |
// | Description : Two-read/one-write register bank with reset-time clearing  |
// |               walk and registered, valid-qualified read path.            |
// |               Optional macro REG_BANK_BYPASS_EN forwards same-cycle      |
// |               write data to a colliding read port.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module reg_bank #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWriteEnable,
    input  logic              regReadEnable,
    input  logic [ADDR_W-1:0] adr_1,
    input  logic [ADDR_W-1:0] adr_2,
    input  logic [ADDR_W-1:0] adr_3,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [0:0]        c_init  = 1'b0;
    localparam logic [0:0]        c_ready = 1'b1;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0]  c_last  = IDX_W'(DEPTH - 1);

    logic [0:0]        state_q,      state_d;
    logic [IDX_W-1:0]  init_ptr_q,   init_ptr_d;
    logic [DATA_W-1:0] rd_data_1_q,  rd_data_1_d;
    logic [DATA_W-1:0] rd_data_2_q,  rd_data_2_d;
    logic              rd_valid_q,   rd_valid_d;
    logic              addr_err_q,   addr_err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              w_in_1, w_in_2, w_in_3;
    logic [DATA_W-1:0] w_rd_1, w_rd_2;
    logic              w_mem_wr_en;
    logic [IDX_W-1:0]  w_mem_wr_idx;
    logic [DATA_W-1:0] w_mem_wr_data;

    // Range checks use one extra bit so DEPTH=256 compares correctly.
    always_comb begin
        w_in_1 = ({1'b0, adr_1} < c_depth);
        w_in_2 = ({1'b0, adr_2} < c_depth);
        w_in_3 = ({1'b0, adr_3} < c_depth);

        w_rd_1 = w_in_1 ? mem_q[adr_1[IDX_W-1:0]] : '0;
        w_rd_2 = w_in_2 ? mem_q[adr_2[IDX_W-1:0]] : '0;
`ifdef REG_BANK_BYPASS_EN
        if (regWriteEnable && w_in_3 && w_in_1 && (adr_1 == adr_3)) begin
            w_rd_1 = WriteData;
        end
        if (regWriteEnable && w_in_3 && w_in_2 && (adr_2 == adr_3)) begin
            w_rd_2 = WriteData;
        end
`endif
    end

    always_comb begin
        state_d       = state_q;
        init_ptr_d    = init_ptr_q;
        rd_data_1_d   = rd_data_1_q;
        rd_data_2_d   = rd_data_2_q;
        rd_valid_d    = 1'b0;
        addr_err_d    = 1'b0;
        w_mem_wr_en   = 1'b0;
        w_mem_wr_idx  = init_ptr_q;
        w_mem_wr_data = '0;

        case (state_q)
            c_init: begin
                w_mem_wr_en = 1'b1;
                if (init_ptr_q == c_last) begin
                    state_d    = c_ready;
                    init_ptr_d = '0;
                end else begin
                    init_ptr_d = init_ptr_q + IDX_W'(1);
                end
            end
            c_ready: begin
                if (regReadEnable) begin
                    rd_data_1_d = w_rd_1;
                    rd_data_2_d = w_rd_2;
                    rd_valid_d  = 1'b1;
                end
                if (regWriteEnable && w_in_3) begin
                    w_mem_wr_en   = 1'b1;
                    w_mem_wr_idx  = adr_3[IDX_W-1:0];
                    w_mem_wr_data = WriteData;
                end
                addr_err_d = (regReadEnable && (!w_in_1 || !w_in_2)) ||
                             (regWriteEnable && !w_in_3);
            end
            default: begin
                state_d = c_init;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= c_init;
            init_ptr_q  <= '0;
            rd_data_1_q <= '0;
            rd_data_2_q <= '0;
            rd_valid_q  <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_ptr_q  <= init_ptr_d;
            rd_data_1_q <= rd_data_1_d;
            rd_data_2_q <= rd_data_2_d;
            rd_valid_q  <= rd_valid_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Storage has no reset; the init walk clears it after every reset.
    always_ff @(posedge clk) begin
        if (w_mem_wr_en) begin
            mem_q[w_mem_wr_idx] <= w_mem_wr_data;
        end
    end

    assign rd_data_1 = rd_data_1_q;
    assign rd_data_2 = rd_data_2_q;
    assign rd_valid  = rd_valid_q;
    assign addr_err  = addr_err_q;
    assign busy      = (state_q == c_init);

endmodule
`default_nettype wire

// File: tb/tb_reg_bank.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_reg_bank                                                |
// | Description : Directed self-checking bench for reg_bank (DEPTH 256 & 16) |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_reg_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic       re = 1'b0;
    logic [7:0] a1 = 8'h00;
    logic [7:0] a2 = 8'h00;
    logic [7:0] a3 = 8'h00;
    logic [7:0] wd = 8'h00;

    logic [7:0] rd1, rd2, rd1_s, rd2_s;
    logic       valid, busy, err, valid_s, busy_s, err_s;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_bank #(.DEPTH(256), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .regWriteEnable(we), .regReadEnable(re),
        .adr_1(a1), .adr_2(a2), .adr_3(a3), .WriteData(wd),
        .rd_data_1(rd1), .rd_data_2(rd2), .rd_valid(valid), .busy(busy),
        .addr_err(err)
    );

    reg_bank #(.DEPTH(16), .ADDR_W(8), .DATA_W(8)) dut_s (
        .clk(clk), .reset(reset), .regWriteEnable(we), .regReadEnable(re),
        .adr_1(a1), .adr_2(a2), .adr_3(a3), .WriteData(wd),
        .rd_data_1(rd1_s), .rd_data_2(rd2_s), .rd_valid(valid_s), .busy(busy_s),
        .addr_err(err_s)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic [7:0] x1,
                         input logic [7:0] x2, input logic [7:0] x3,
                         input logic [7:0] d);
        @(negedge clk);
        we = w; re = r; a1 = x1; a2 = x2; a3 = x3; wd = d;
    endtask

    task automatic idle;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    endtask

    // Counts edges until the 256-deep bank drops busy (bounded).
    task automatic walk_len(output int n);
        n = 0;
        for (int i = 0; i < 600; i++) begin
            tick;
            n++;
            if (!busy) break;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_run++;
        if ({rd1, rd2, valid, err, busy} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_256: got rd1=%h rd2=%h v=%b e=%b b=%b want 00 00 0 0 1",
                     rd1, rd2, valid, err, busy);
        end
        n_run++;
        if ({rd1_s, rd2_s, valid_s, err_s, busy_s} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_16: got rd1=%h rd2=%h v=%b e=%b b=%b want 00 00 0 0 1",
                     rd1_s, rd2_s, valid_s, err_s, busy_s);
        end
    endtask

    task automatic test_init_walk;
        int n;
        int n_s;
        n = 0;
        n_s = -1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick;
            n++;
            if (!busy_s && n_s < 0) n_s = n;
            if (!busy) break;
        end
        n_run++;
        if (n !== 256) begin
            n_fail++;
            $display("FAIL walk_len_256: got %0d cycles want 256", n);
        end
        n_run++;
        if (n_s !== 16) begin
            n_fail++;
            $display("FAIL walk_len_16: got %0d cycles want 16", n_s);
        end
        drive(1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'h00);
        tick;
        n_run++;
        if ({rd1, rd2, valid} !== {8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL first_read: got rd1=%h rd2=%h v=%b want 00 00 1", rd1, rd2, valid);
        end
        idle;
        tick;
        n_run++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL first_read_pulse: got v=%b want 0", valid);
        end
    endtask

    task automatic test_write_read;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h10, 8'h5A);
        tick;
        drive(1'b0, 1'b1, 8'h10, 8'h11, 8'h00, 8'h00);
        tick;
        n_run++;
        if ({rd1, rd2, valid} !== {8'h5A, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL write_read: got rd1=%h rd2=%h v=%b want 5a 00 1", rd1, rd2, valid);
        end
        idle;
        tick;
        n_run++;
        if ({rd1, valid} !== {8'h5A, 1'b0}) begin
            n_fail++;
            $display("FAIL read_hold: got rd1=%h v=%b want 5a 0", rd1, valid);
        end
    endtask

    task automatic test_collision;
        logic [7:0] exp;
`ifdef REG_BANK_BYPASS_EN
        exp = 8'h77;
`else
        exp = 8'h11;
`endif
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h20, 8'h11);
        tick;
        drive(1'b1, 1'b1, 8'h20, 8'h21, 8'h20, 8'h77);
        tick;
        n_run++;
        if ({rd1, rd2} !== {exp, 8'h00}) begin
            n_fail++;
            $display("FAIL collision: got rd1=%h rd2=%h want %h 00", rd1, rd2, exp);
        end
        drive(1'b0, 1'b1, 8'h20, 8'h21, 8'h00, 8'h00);
        tick;
        n_run++;
        if (rd1 !== 8'h77) begin
            n_fail++;
            $display("FAIL collision_after: got rd1=%h want 77", rd1);
        end
    endtask

    task automatic test_range;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h03, 8'h3C);
        tick;
        drive(1'b1, 1'b1, 8'h20, 8'h03, 8'h20, 8'hAA);
        tick;
        n_run++;
        if ({err_s, valid_s, rd1_s, rd2_s} !== {1'b1, 1'b1, 8'h00, 8'h3C}) begin
            n_fail++;
            $display("FAIL range_read: got e=%b v=%b rd1=%h rd2=%h want 1 1 00 3c",
                     err_s, valid_s, rd1_s, rd2_s);
        end
        n_run++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL range_full_depth: got e=%b want 0", err);
        end
        idle;
        tick;
        n_run++;
        if (err_s !== 1'b0) begin
            n_fail++;
            $display("FAIL range_pulse: got e=%b want 0", err_s);
        end
        // Index 0 aliases 0x10/0x20, which were only ever written out of range.
        drive(1'b0, 1'b1, 8'h00, 8'h03, 8'h00, 8'h00);
        tick;
        n_run++;
        if ({rd1_s, rd2_s, err_s} !== {8'h00, 8'h3C, 1'b0}) begin
            n_fail++;
            $display("FAIL range_no_change: got rd1=%h rd2=%h e=%b want 00 3c 0",
                     rd1_s, rd2_s, err_s);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        drive(1'b1, 1'b0, 8'h00, 8'h00, 8'h05, 8'h33);
        tick;
        drive(1'b0, 1'b1, 8'h05, 8'h05, 8'h00, 8'h00);
        tick;
        n_run++;
        if ({rd1, valid} !== {8'h33, 1'b1}) begin
            n_fail++;
            $display("FAIL pre_reset_read: got rd1=%h v=%b want 33 1", rd1, valid);
        end
        @(negedge clk);
        reset = 1'b1;
        we = 1'b0; re = 1'b0;
        #1;
        n_run++;
        if ({rd1, rd2, valid, err, busy} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset_ready: got rd1=%h rd2=%h v=%b e=%b b=%b want 00 00 0 0 1",
                     rd1, rd2, valid, err, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (10) tick;
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_init: got b=%b want 1", busy);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_run++;
        if ({rd1, rd2, valid, err, busy} !== {8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL async_reset_init: got rd1=%h rd2=%h v=%b e=%b b=%b want 00 00 0 0 1",
                     rd1, rd2, valid, err, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        walk_len(n);
        n_run++;
        if (n !== 256) begin
            n_fail++;
            $display("FAIL restart_walk_len: got %0d cycles want 256", n);
        end
        drive(1'b0, 1'b1, 8'h05, 8'h03, 8'h00, 8'h00);
        tick;
        n_run++;
        if ({rd1, rd2, valid} !== {8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_clears: got rd1=%h rd2=%h v=%b want 00 00 1", rd1, rd2, valid);
        end
    endtask

    task automatic test_init_strobes;
        int n;
        @(negedge clk);
        reset = 1'b1;
        re = 1'b0; we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'h01, 8'h01, 8'h01, 8'hFF);
            tick;
            n_run++;
            if ({valid, err, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL init_strobe[%0d]: got v=%b e=%b b=%b want 0 0 1",
                         i, valid, err, busy);
            end
        end
        idle;
        walk_len(n);
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_strobe_ready: got b=%b after %0d cycles want 0", busy, n);
        end
        drive(1'b0, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00);
        tick;
        n_run++;
        if ({rd1, rd2, valid} !== {8'h00, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL init_strobe_ignored: got rd1=%h rd2=%h v=%b want 00 00 1",
                     rd1, rd2, valid);
        end
    endtask

    initial begin
        test_reset;
        test_init_walk;
        test_write_read;
        test_collision;
        test_range;
        test_reset_mid;
        test_init_strobes;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
